rr_job_arbiter: RTL

- Round-robin arbiter and sequencer that shares one compute resource (e.g. a MAC/layer engine) among NUM_REQ requesters.
- Grants one requester at a time and issues a one-cycle start pulse to the resource.
- Holds the grant until the resource reports done, then rotates priority.
- Provides a "running" busy flag and an optional hold timeout that forcibly releases a hung job.

---
 rtl/rr_job_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rr_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one compute resource among NUM_REQ requesters.
// Grants one job at a time, pulses start, holds until done (or optional timeout), then rotates priority.
module rr_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             srst_i,
    input  logic [NUM_REQ-1:0]                               req_i,
    input  logic                                             done_i,
    output logic [NUM_REQ-1:0]                               grant_o,
    output logic                                             start_o,
    output logic                                             busy_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o,
    output logic                                             timeout_o,
    input  logic                                             assert_on_i
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("rr_job_arbiter: NUM_REQ must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_prev_q;

    logic               req_found;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   owner_next;
    logic               hold_expired;

    // First requesting index at or after ptr_q, wrapping modulo NUM_REQ.
    always_comb begin : arbitrate
        int unsigned cand;
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!req_found && req_i[IDX_W'(cand)]) begin
                req_found = 1'b1;
                req_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_next   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign hold_expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin : fsm_next
        state_d   = state_q;
        grant_d   = grant_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = START;
                    owner_d = req_idx;
                    grant_d = NUM_REQ'(1) << req_idx;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done takes precedence over a simultaneous timeout.
                if (done_i || hold_expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                    if (!done_i) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : regs
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            owner_q      <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
        end else if (srst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            owner_q      <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_q;
        end
    end

    assign grant_o   = grant_q;
    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

    // Protocol checks, enabled at run time by assert_on_i.
    always @(posedge clk_i) begin : protocol_checks
        if (!rst_i && !srst_i && assert_on_i) begin
            assert ($onehot0(grant_q)) else $error("rr_job_arbiter: grant not one-hot");
            assert (!(start_q && start_prev_q)) else $error("rr_job_arbiter: start held two cycles");
            assert (!(done_i && state_q == IDLE)) else $error("rr_job_arbiter: done while idle");
            assert (!(done_i && state_q == START)) else $error("rr_job_arbiter: done in start cycle");
        end
    end

endmodule
